// File: rtl/rf_seq_pkg.sv
// rf_seq_pkg: shared definitions for the RF front-end mode sequencer.
//   - RF mode codes and their front-end pin patterns
//   - quiesce mask driven on pins[2:0] while the path switches move
//   - sequencer FSM state enum
//   - helpers to map a mode code to its pattern and to validate a code
package rf_seq_pkg;

  localparam int unsigned PIN_W  = 8;
  localparam int unsigned MODE_W = 3;

  // Mode codes
  localparam logic [MODE_W-1:0] MODE_LOW_POWER = 3'b000;
  localparam logic [MODE_W-1:0] MODE_BYPASS    = 3'b001;
  localparam logic [MODE_W-1:0] MODE_RX_LPF    = 3'b010;
  localparam logic [MODE_W-1:0] MODE_RX_HPF    = 3'b011;
  localparam logic [MODE_W-1:0] MODE_TX_LPF    = 3'b100;
  localparam logic [MODE_W-1:0] MODE_TX_HPF    = 3'b101;

  // Pin patterns, bit order {rx_h, rx_h_b, tr_vc1, tr_vc1_b, tr_vc2, shdn_tx_lna, shdn_rx_lna, mixer_en}
  localparam logic [PIN_W-1:0] PAT_LOW_POWER = 8'h56;
  localparam logic [PIN_W-1:0] PAT_BYPASS    = 8'h66;
  localparam logic [PIN_W-1:0] PAT_RX_LPF    = 8'h9D;
  localparam logic [PIN_W-1:0] PAT_RX_HPF    = 8'h5D;
  localparam logic [PIN_W-1:0] PAT_TX_LPF    = 8'h6B;
  localparam logic [PIN_W-1:0] PAT_TX_HPF    = 8'hAB;

  // Mixer off, both LNAs shut down
  localparam logic [2:0] QUIESCE_MASK = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_QUIESCE = 3'd1,
    ST_GUARD   = 3'd2,
    ST_SWITCH  = 3'd3,
    ST_SETTLE  = 3'd4,
    ST_ENABLE  = 3'd5
  } seq_state_e;

  function automatic logic [PIN_W-1:0] mode_pattern(input logic [MODE_W-1:0] mode);
    case (mode)
      MODE_LOW_POWER: return PAT_LOW_POWER;
      MODE_BYPASS:    return PAT_BYPASS;
      MODE_RX_LPF:    return PAT_RX_LPF;
      MODE_RX_HPF:    return PAT_RX_HPF;
      MODE_TX_LPF:    return PAT_TX_LPF;
      MODE_TX_HPF:    return PAT_TX_HPF;
      default:        return PAT_LOW_POWER;
    endcase
  endfunction

  function automatic logic mode_code_ok(input logic [MODE_W-1:0] mode);
    return (mode <= MODE_TX_HPF);
  endfunction

endpackage

// File: rtl/rf_mode_sequencer_if.sv
// rf_mode_sequencer_if: mode request valid/ready handshake with the
// guard and settle cycle counts that travel with each request.
//   i_mode_req       requested RF mode code
//   i_mode_valid     request valid
//   o_mode_ready     sequencer ready to accept
//   i_guard_cycles   dead time after LNAs/mixer shut down
//   i_settle_cycles  switch settling time before enable
// master: request source, slave: sequencer.
interface rf_mode_sequencer_if #(
  parameter int unsigned CNT_W = 8
);
  import rf_seq_pkg::*;

  logic [MODE_W-1:0] i_mode_req;
  logic              i_mode_valid;
  logic              o_mode_ready;
  logic [CNT_W-1:0]  i_guard_cycles;
  logic [CNT_W-1:0]  i_settle_cycles;

  modport master (
    output i_mode_req, i_mode_valid, i_guard_cycles, i_settle_cycles,
    input  o_mode_ready
  );

  modport slave (
    input  i_mode_req, i_mode_valid, i_guard_cycles, i_settle_cycles,
    output o_mode_ready
  );

endinterface

// File: rtl/rf_seq_timer.sv
// rf_seq_timer: CNT_W down-counter shared by the GUARD and SETTLE phases.
//   i_sys_clk, i_reset  clock, synchronous active-high reset
//   load, load_val      load a new count (takes priority over dec)
//   dec                 decrement while non-zero; never wraps below zero
//   zero_c              count has reached zero (combinational)
module rf_seq_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_sys_clk,
  input  logic             i_reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt_q;

  // Count register
  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/rf_mode_sequencer.sv
// rf_mode_sequencer: break-before-make sequencer for RF front-end modes.
// A request walks QUIESCE -> GUARD -> SWITCH -> SETTLE -> ENABLE so the
// path switches (pins[7:3]) only move while mixer/LNAs are shut down.
// Ports:
//   i_sys_clk, i_reset  clock, synchronous active-high reset
//   req_if              mode request handshake + guard/settle counts
//   o_rf_pins           registered front-end pins
//   o_cur_mode          last completed mode
//   o_busy              sequence in progress
//   o_done, o_err       one-cycle completion / invalid-code pulses
// Optional build macro RF_SEQ_DBG_BYPASS_EN adds i_dbg_en / i_dbg_pins,
// which override the pins and hold the FSM in IDLE.
module rf_mode_sequencer
  import rf_seq_pkg::*;
#(
  parameter int unsigned      CNT_W      = 8,
  parameter logic [PIN_W-1:0] RESET_PINS = 8'h56
) (
  input  logic                i_sys_clk,
  input  logic                i_reset,
  rf_mode_sequencer_if.slave  req_if,
`ifdef RF_SEQ_DBG_BYPASS_EN
  input  logic                i_dbg_en,
  input  logic [PIN_W-1:0]    i_dbg_pins,
`endif
  output logic [PIN_W-1:0]    o_rf_pins,
  output logic [MODE_W-1:0]   o_cur_mode,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err
);

  seq_state_e        state_q, state_d;
  logic [PIN_W-1:0]  pins_q, pins_d;
  logic [MODE_W-1:0] cur_mode_q, cur_mode_d;
  logic [MODE_W-1:0] target_q, target_d;
  logic [CNT_W-1:0]  settle_q, settle_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_load_val;
  logic              tmr_dec;
  logic              tmr_zero_c;
  logic              accept_c;
  logic [PIN_W-1:0]  tgt_pat_c;

`ifdef RF_SEQ_DBG_BYPASS_EN
  logic              dbg_q;
`endif

  assign tgt_pat_c = mode_pattern(target_q);

  // Guard count is held by the timer itself from acceptance onward
  rf_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .i_sys_clk (i_sys_clk),
    .i_reset   (i_reset),
    .load      (tmr_load),
    .load_val  (tmr_load_val),
    .dec       (tmr_dec),
    .zero_c    (tmr_zero_c)
  );

  // State and output registers
  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      pins_q     <= RESET_PINS;
      cur_mode_q <= MODE_LOW_POWER;
      target_q   <= MODE_LOW_POWER;
      settle_q   <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef RF_SEQ_DBG_BYPASS_EN
      dbg_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pins_q     <= pins_d;
      cur_mode_q <= cur_mode_d;
      target_q   <= target_d;
      settle_q   <= settle_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef RF_SEQ_DBG_BYPASS_EN
      dbg_q      <= i_dbg_en;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    pins_d       = pins_q;
    cur_mode_d   = cur_mode_q;
    target_d     = target_q;
    settle_d     = settle_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_dec      = 1'b0;
    // ready_q is only ever set while in IDLE
    accept_c     = ready_q && req_if.i_mode_valid;
`ifdef RF_SEQ_DBG_BYPASS_EN
    accept_c     = accept_c && !i_dbg_en;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          if (!mode_code_ok(req_if.i_mode_req)) begin
            err_d = 1'b1;
          end else if (req_if.i_mode_req == cur_mode_q) begin
            done_d = 1'b1;
          end else begin
            target_d     = req_if.i_mode_req;
            settle_d     = req_if.i_settle_cycles;
            tmr_load     = 1'b1;
            tmr_load_val = req_if.i_guard_cycles;
            state_d      = ST_QUIESCE;
          end
        end
      end
      ST_QUIESCE: begin
        pins_d  = {pins_q[7:3], QUIESCE_MASK};
        state_d = ST_GUARD;
      end
      ST_GUARD: begin
        if (tmr_zero_c) state_d = ST_SWITCH;
        else            tmr_dec = 1'b1;
      end
      ST_SWITCH: begin
        pins_d       = {tgt_pat_c[7:3], QUIESCE_MASK};
        tmr_load     = 1'b1;
        tmr_load_val = settle_q;
        state_d      = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (tmr_zero_c) state_d = ST_ENABLE;
        else            tmr_dec = 1'b1;
      end
      ST_ENABLE: begin
        pins_d     = tgt_pat_c;
        cur_mode_d = target_q;
        done_d     = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef RF_SEQ_DBG_BYPASS_EN
    // Debug override aborts any sequence; release restores the current mode
    if (i_dbg_en) begin
      state_d    = ST_IDLE;
      pins_d     = i_dbg_pins;
      cur_mode_d = cur_mode_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
    end else if (dbg_q) begin
      pins_d     = mode_pattern(cur_mode_q);
    end
`endif

    ready_d = (state_d == ST_IDLE);
`ifdef RF_SEQ_DBG_BYPASS_EN
    ready_d = ready_d && !i_dbg_en;
`endif
    busy_d  = (state_d != ST_IDLE);
  end

  assign req_if.o_mode_ready = ready_q;
  assign o_rf_pins           = pins_q;
  assign o_cur_mode          = cur_mode_q;
  assign o_busy              = busy_q;
  assign o_done              = done_q;
  assign o_err               = err_q;

endmodule

// File: doc/rf_mode_sequencer.md
RF_MODE_SEQUENCER -- requirements
Module: rf_mode_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the guard and settle cycle counts.
REQ-002 SHALL have parameter RESET_PINS, default 8'h56, the pin pattern driven during reset (the low-power pattern).
REQ-003 SHALL have `i_sys_clk  in  1  clock`; all logic is on the rising edge.
REQ-004 SHALL have `i_reset  in  1  reset`, synchronous, active-high.
REQ-005 SHALL have `i_mode_req  in  3  requested RF mode`: 000 low_power, 001 bypass, 010 rx_lpf, 011 rx_hpf, 100 tx_lpf, 101 tx_hpf.
REQ-006 SHALL have `i_mode_valid  in  1` and `o_mode_ready  out  1`, a valid/ready request handshake.
REQ-007 SHALL have `i_guard_cycles  in  CNT_W`, the dead time after the LNAs and mixer are shut down.
REQ-008 SHALL have `i_settle_cycles  in  CNT_W`, the switch settling time before enable.
REQ-009 SHALL have `o_rf_pins  out  8  registered front-end pins`:
- [0] mixer_en
- [1] shdn_rx_lna
- [2] shdn_tx_lna
- [3] tr_vc2
- [4] tr_vc1_b
- [5] tr_vc1
- [6] rx_h_b
- [7] rx_h
REQ-010 SHALL have `o_cur_mode  out  3` (last completed mode), `o_busy  out  1`, `o_done  out  1` (pulse) and `o_err  out  1` (pulse).

Function
REQ-011 Target patterns SHALL be:
- low_power 8'h56
- bypass 8'h66
- rx_lpf 8'h9D
- rx_hpf 8'h5D
- tx_lpf 8'h6B
- tx_hpf 8'hAB
REQ-012 The FSM SHALL have the states IDLE, QUIESCE, GUARD, SWITCH, SETTLE, ENABLE.
REQ-013 o_mode_ready SHALL be 1 only in IDLE; a request is accepted on a cycle with i_mode_valid && o_mode_ready.
REQ-014 On acceptance, the FSM SHALL latch the target, i_guard_cycles and i_settle_cycles; later changes to these inputs SHALL NOT affect the sequence in progress.
REQ-015 An accepted code 110 or 111 SHALL pulse o_err for 1 cycle, leave the pins and o_cur_mode unchanged, and stay in IDLE.
REQ-016 An accepted code equal to o_cur_mode SHALL pulse o_done on the next cycle, with no pin activity and no sequence.
REQ-017 QUIESCE SHALL last 1 cycle and drive pins[7:3] from the current pattern with pins[2:0]=3'b110 (mixer off, both LNAs shut down).
REQ-018 GUARD SHALL hold the QUIESCE pattern for latched_guard+1 cycles.
REQ-019 SWITCH SHALL last 1 cycle and drive pins[7:3] from the target with pins[2:0]=3'b110.
REQ-020 SETTLE SHALL hold the SWITCH pattern for latched_settle+1 cycles.
REQ-021 ENABLE SHALL last 1 cycle: drive the full target pattern, update o_cur_mode, pulse o_done, then return to IDLE.
REQ-022 Accept-to-o_done latency SHALL be exactly G+S+5 cycles, counting from the accepting edge.
REQ-023 Counts of all-ones SHALL NOT wrap; a count of 0 still yields 1 cycle in the state.
REQ-024 No cycle SHALL ever have a path switch bit ([7:3]) change while pins[2:0] != 3'b110 (break-before-make).
REQ-025 o_busy SHALL be 1 in every state except IDLE.
REQ-026 o_done and o_err SHALL NOT be asserted in the same cycle.

Reset
REQ-027 On i_reset, the block SHALL enter IDLE with:
- o_rf_pins=RESET_PINS
- o_cur_mode=000
- o_busy=0, o_done=0, o_err=0
- o_mode_ready=0 during reset, 1 on the first cycle after reset.
REQ-028 Reset mid-sequence SHALL abort immediately to the reset values, with no o_done.

Configuration
REQ-029 RF_SEQ_DBG_BYPASS_EN defined SHALL add the ports `i_dbg_en  in  1` and `i_dbg_pins  in  8`.
REQ-030 While i_dbg_en=1 (RF_SEQ_DBG_BYPASS_EN defined):
- o_rf_pins SHALL equal i_dbg_pins with 1-cycle latency
- the FSM SHALL be forced to IDLE, with o_mode_ready=0
- any sequence in progress SHALL be aborted without o_done.
REQ-031 When i_dbg_en falls (RF_SEQ_DBG_BYPASS_EN defined), o_rf_pins SHALL be restored to the o_cur_mode pattern on the next cycle.
REQ-032 RF_SEQ_DBG_BYPASS_EN undefined SHALL remove both debug ports, and behaviour is REQ-011..REQ-028 only.

Structure
REQ-033 Shared package rf_seq_pkg SHALL hold:
- the mode codes
- the six pattern constants
- the 3'b110 quiesce mask
- the FSM state enum.
REQ-034 Guard and settle timing SHALL use one sub-module, rf_seq_timer: a CNT_W down-counter with load/expire, instantiated once and shared by GUARD and SETTLE.

Verification
REQ-035 After reset with no requests, the bench SHALL check pins=8'h56, cur_mode=000 and ready=1.
REQ-036 Request 010 with G=2, S=3 SHALL produce:
- pins 56 -> 56 (QUIESCE) -> 9E (SWITCH) -> 9D (ENABLE)
- o_done exactly 10 cycles after acceptance
- cur_mode=010.
REQ-037 From rx_lpf, request 101 with G=0, S=0 SHALL produce pins 9E, 9E, AE, AE, AB and o_done at accept+5; the bench SHALL check REQ-024 on every cycle.
REQ-038 Request 111 SHALL pulse o_err for 1 cycle with pins unchanged; a request equal to the current mode SHALL give o_done on the next cycle with no pin change.
REQ-039 Holding i_mode_valid during busy SHALL not be accepted until IDLE; changing i_guard_cycles mid-sequence SHALL not change the latency.
REQ-040 i_reset in the SETTLE state SHALL give pins=56 on the next cycle and no o_done; with the macro defined, i_dbg_en=1 with dbg_pins=FF SHALL give pins=FF after 1 cycle and abort the sequence.
